// File: rtl/tile_mac_engine.sv
// Tile compute engine: signed matmul / matmul-accumulate / elementwise add-sub from A,B SRAMs into C SRAM.
// Latency: TM*TN*(K+2)+1 cycles start->done (+TM*TN for MATMUL_ACC); K=TK for matmul, K=1 elementwise.
// Backpressure: none; SRAMs are always ready with 1-cycle read latency, start is ignored unless idle.
//
// Ports:
//   clk, rst_n            clock (rising edge) and asynchronous active-low reset
//   start, op, shift      operation request; op/shift/bases captured when start is accepted in IDLE
//   a_base/b_base/c_base  tile base addresses
//   a_addr/a_dout         A read port (data valid the cycle after the address)
//   b_addr/b_dout         B read port (data valid the cycle after the address)
//   c_addr/c_we/c_din     C read/write port; c_dout is read data (1-cycle latency)
//   busy, done            busy while working; done is a one-cycle pulse after the last write
module tile_mac_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32,
    parameter int TM     = 4,
    parameter int TN     = 4,
    parameter int TK     = 16,
    parameter int ADDR_W = 10
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               op,
    input  logic [$clog2(ACC_W)-1:0] shift,
    input  logic [ADDR_W-1:0]        a_base,
    input  logic [ADDR_W-1:0]        b_base,
    input  logic [ADDR_W-1:0]        c_base,
    output logic [ADDR_W-1:0]        a_addr,
    output logic [ADDR_W-1:0]        b_addr,
    input  logic [DATA_W-1:0]        a_dout,
    input  logic [DATA_W-1:0]        b_dout,
    output logic [ADDR_W-1:0]        c_addr,
    output logic                     c_we,
    output logic [DATA_W-1:0]        c_din,
    input  logic [DATA_W-1:0]        c_dout,
    output logic                     busy,
    output logic                     done
);

    localparam int SH_W = $clog2(ACC_W);
    localparam int IW   = (TM > 1) ? $clog2(TM) : 1;
    localparam int JW   = (TN > 1) ? $clog2(TN) : 1;
    localparam int KW   = (TK > 1) ? $clog2(TK) : 1;

    localparam logic [ADDR_W-1:0] TN_A   = ADDR_W'(TN);
    localparam logic [ADDR_W-1:0] TK_A   = ADDR_W'(TK);
    localparam logic [IW-1:0]     I_LAST = IW'(TM - 1);
    localparam logic [JW-1:0]     J_LAST = JW'(TN - 1);
    localparam logic [KW-1:0]     K_LAST = KW'(TK - 1);

    // Saturation bounds of a DATA_W signed element, held at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        OP_MATMUL     = 2'd0,
        OP_MATMUL_ACC = 2'd1,
        OP_ADD        = 2'd2,
        OP_SUB        = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RDC,
        S_MAC,
        S_DRAIN,
        S_WRITE,
        S_FIN
    } state_t;

    state_t                    state;
    op_t                       op_q;
    logic [SH_W-1:0]           shift_q;
    logic [ADDR_W-1:0]         a_base_q;
    logic [ADDR_W-1:0]         b_base_q;
    logic [ADDR_W-1:0]         c_base_q;
    logic [IW-1:0]             i;
    logic [JW-1:0]             j;
    logic [KW-1:0]             k;
    logic signed [ACC_W-1:0]   acc;

    // Datapath
    logic signed [ACC_W-1:0]   a_ext;
    logic signed [ACC_W-1:0]   b_ext;
    logic signed [ACC_W-1:0]   c_ext;
    logic signed [ACC_W-1:0]   term;
    logic signed [ACC_W-1:0]   acc_sum;
    logic signed [ACC_W-1:0]   acc_shr;
    logic [DATA_W-1:0]         sat_val;

    // Loop bookkeeping
    logic                      elw;
    logic                      i_last;
    logic                      j_last;
    logic                      k_last;
    logic [IW-1:0]             i_nxt;
    logic [JW-1:0]             j_nxt;
    logic [ADDR_W-1:0]         elem_off;
    logic [ADDR_W-1:0]         nxt_off;

    // Operand address generators. Elementwise ops walk A and B with the C layout;
    // matmul walks row i of A and column j of B along k.
    function automatic logic [ADDR_W-1:0] a_at(input logic              ew,
                                               input logic [ADDR_W-1:0] base,
                                               input logic [ADDR_W-1:0] ii,
                                               input logic [ADDR_W-1:0] jj,
                                               input logic [ADDR_W-1:0] kk);
        return ew ? (base + ii * TN_A + jj) : (base + ii * TK_A + kk);
    endfunction

    function automatic logic [ADDR_W-1:0] b_at(input logic              ew,
                                               input logic [ADDR_W-1:0] base,
                                               input logic [ADDR_W-1:0] ii,
                                               input logic [ADDR_W-1:0] jj,
                                               input logic [ADDR_W-1:0] kk);
        return ew ? (base + ii * TN_A + jj) : (base + kk * TN_A + jj);
    endfunction

    always_comb begin
        a_ext = {{(ACC_W-DATA_W){a_dout[DATA_W-1]}}, a_dout};
        b_ext = {{(ACC_W-DATA_W){b_dout[DATA_W-1]}}, b_dout};
        c_ext = {{(ACC_W-DATA_W){c_dout[DATA_W-1]}}, c_dout};

        case (op_q)
            OP_ADD:  term = a_ext + b_ext;
            OP_SUB:  term = a_ext - b_ext;
            default: term = a_ext * b_ext;
        endcase

        acc_sum = acc + term;
        // Arithmetic shift on a signed value floors toward minus infinity.
        acc_shr = acc_sum >>> shift_q;

        if (acc_shr > SAT_MAX) begin
            sat_val = SAT_MAX[DATA_W-1:0];
        end else if (acc_shr < SAT_MIN) begin
            sat_val = SAT_MIN[DATA_W-1:0];
        end else begin
            sat_val = acc_shr[DATA_W-1:0];
        end
    end

    always_comb begin
        elw      = (op_q == OP_ADD) || (op_q == OP_SUB);
        i_last   = (i == I_LAST);
        j_last   = (j == J_LAST);
        k_last   = elw ? (k == '0) : (k == K_LAST);
        // i_nxt overflows after the last element, but that value is never used.
        i_nxt    = j_last ? i + 1'b1 : i;
        j_nxt    = j_last ? '0 : j + 1'b1;
        elem_off = ADDR_W'(i) * TN_A + ADDR_W'(j);
        nxt_off  = ADDR_W'(i_nxt) * TN_A + ADDR_W'(j_nxt);
    end

    // All outputs are registered and updated on the edge that enters the state
    // they belong to, so an address issued "in cycle k" is stable for all of cycle k.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            op_q     <= OP_MATMUL;
            shift_q  <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            c_base_q <= '0;
            i        <= '0;
            j        <= '0;
            k        <= '0;
            acc      <= '0;
            a_addr   <= '0;
            b_addr   <= '0;
            c_addr   <= '0;
            c_we     <= 1'b0;
            c_din    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    c_we <= 1'b0;
                    if (start) begin
                        op_q     <= op_t'(op);
                        shift_q  <= shift;
                        a_base_q <= a_base;
                        b_base_q <= b_base;
                        c_base_q <= c_base;
                        i        <= '0;
                        j        <= '0;
                        k        <= '0;
                        busy     <= 1'b1;
                        if (op_t'(op) == OP_MATMUL_ACC) begin
                            state  <= S_RDC;
                            c_addr <= c_base;
                        end else begin
                            state  <= S_MAC;
                            a_addr <= a_at(op[1], a_base, '0, '0, '0);
                            b_addr <= b_at(op[1], b_base, '0, '0, '0);
                        end
                    end
                end

                // c_addr already points at the element; its data lands in the first MAC cycle.
                S_RDC: begin
                    state  <= S_MAC;
                    k      <= '0;
                    a_addr <= a_at(elw, a_base_q, ADDR_W'(i), ADDR_W'(j), '0);
                    b_addr <= b_at(elw, b_base_q, ADDR_W'(i), ADDR_W'(j), '0);
                end

                S_MAC: begin
                    // First MAC cycle has no operand yet: seed the accumulator instead.
                    if (k == '0) begin
                        acc <= (op_q == OP_MATMUL_ACC) ? c_ext : '0;
                    end else begin
                        acc <= acc_sum;
                    end
                    if (k_last) begin
                        state <= S_DRAIN;
                    end else begin
                        k      <= k + 1'b1;
                        a_addr <= a_at(elw, a_base_q, ADDR_W'(i), ADDR_W'(j), ADDR_W'(k + 1'b1));
                        b_addr <= b_at(elw, b_base_q, ADDR_W'(i), ADDR_W'(j), ADDR_W'(k + 1'b1));
                    end
                end

                // Last operand pair arrives here; the result is formed straight from acc_sum.
                S_DRAIN: begin
                    acc    <= acc_sum;
                    c_din  <= sat_val;
                    c_addr <= c_base_q + elem_off;
                    c_we   <= 1'b1;
                    state  <= S_WRITE;
                end

                S_WRITE: begin
                    c_we <= 1'b0;
                    if (i_last && j_last) begin
                        state <= S_FIN;
                    end else begin
                        i <= i_nxt;
                        j <= j_nxt;
                        k <= '0;
                        if (op_q == OP_MATMUL_ACC) begin
                            state  <= S_RDC;
                            c_addr <= c_base_q + nxt_off;
                        end else begin
                            state  <= S_MAC;
                            a_addr <= a_at(elw, a_base_q, ADDR_W'(i_nxt), ADDR_W'(j_nxt), '0);
                            b_addr <= b_at(elw, b_base_q, ADDR_W'(i_nxt), ADDR_W'(j_nxt), '0);
                        end
                    end
                end

                // done rises as FIN is left, so the done cycle is already IDLE and can accept start.
                S_FIN: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    c_we  <= 1'b0;
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tile_mac_engine.sv
// Self-checking bench for tile_mac_engine with behavioural SRAM models and a write scoreboard.
// Latency: checks start->done cycle counts for every op type.
// Backpressure: none in the DUT; the bench also exercises ignored start requests.
module tb_tile_mac_engine;

    localparam int TM = 4;
    localparam int TN = 4;
    localparam int TK = 16;

    localparam int OP_MM    = 0;
    localparam int OP_MMACC = 1;
    localparam int OP_ADD   = 2;
    localparam int OP_SUB   = 3;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start  = 1'b0;
    logic [1:0] op     = 2'd0;
    logic [4:0] shift  = 5'd0;
    logic [9:0] a_base = 10'd0;
    logic [9:0] b_base = 10'd0;
    logic [9:0] c_base = 10'd0;
    logic [9:0] a_addr;
    logic [9:0] b_addr;
    logic [9:0] c_addr;
    logic [7:0] a_dout = 8'd0;
    logic [7:0] b_dout = 8'd0;
    logic [7:0] c_dout = 8'd0;
    logic       c_we;
    logic [7:0] c_din;
    logic       busy;
    logic       done;

    logic [7:0] a_mem [0:1023];
    logic [7:0] b_mem [0:1023];
    logic [7:0] c_mem [0:1023];

    typedef struct {
        logic [9:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_w;

    int cyc         = 0;
    int t_start     = 0;
    int vectors     = 0;
    int miscompares = 0;

    tile_mac_engine dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .shift  (shift),
        .a_base (a_base),
        .b_base (b_base),
        .c_base (c_base),
        .a_addr (a_addr),
        .b_addr (b_addr),
        .a_dout (a_dout),
        .b_dout (b_dout),
        .c_addr (c_addr),
        .c_we   (c_we),
        .c_din  (c_din),
        .c_dout (c_dout),
        .busy   (busy),
        .done   (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous SRAMs: read data valid the cycle after the address.
    always @(posedge clk) begin
        a_dout <= a_mem[a_addr];
        b_dout <= b_mem[b_addr];
        c_dout <= c_mem[c_addr];
        if (c_we) c_mem[c_addr] = c_din;
    end

    // Scoreboard: every C write must match the next expected (address, data).
    always @(negedge clk) begin
        if (c_we === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL c_write_unexpected got addr=%0d data=%0d, no write expected", c_addr, $signed(c_din));
            end else begin
                mon_w = exp_q.pop_front();
                if (c_addr !== mon_w.addr || c_din !== mon_w.data) begin
                    miscompares++;
                    $display("FAIL c_write got addr=%0d data=%0d expected addr=%0d data=%0d",
                             c_addr, $signed(c_din), mon_w.addr, $signed(mon_w.data));
                end
            end
        end
    end

    // Reference: full-precision sum, floor shift, clamp to int8.
    function automatic logic [7:0] model_elem(input int opv, input int sh, input int ab,
                                              input int bb, input int cb, input int i, input int j);
        longint acc;
        longint av;
        longint bv;
        acc = 0;
        if (opv == OP_MMACC) acc = longint'($signed(c_mem[(cb + i*TN + j) & 1023]));
        if (opv == OP_MM || opv == OP_MMACC) begin
            for (int kk = 0; kk < TK; kk++) begin
                av  = longint'($signed(a_mem[(ab + i*TK + kk) & 1023]));
                bv  = longint'($signed(b_mem[(bb + kk*TN + j) & 1023]));
                acc = acc + av * bv;
            end
        end else begin
            av  = longint'($signed(a_mem[(ab + i*TN + j) & 1023]));
            bv  = longint'($signed(b_mem[(bb + i*TN + j) & 1023]));
            acc = (opv == OP_ADD) ? av + bv : av - bv;
        end
        acc = acc >>> sh;
        if (acc > 127)  acc = 127;
        if (acc < -128) acc = -128;
        return acc[7:0];
    endfunction

    task automatic push_expected(input int opv, input int sh, input int ab, input int bb, input int cb);
        wr_t e;
        for (int i = 0; i < TM; i++) begin
            for (int j = 0; j < TN; j++) begin
                e.addr = 10'(cb + i*TN + j);
                e.data = model_elem(opv, sh, ab, bb, cb, i, j);
                exp_q.push_back(e);
            end
        end
    endtask

    task automatic fill(input int which, input int base, input int n, input int val, input bit rnd);
        logic [7:0] v;
        for (int x = 0; x < n; x++) begin
            v = rnd ? 8'($urandom) : 8'(val);
            case (which)
                0:       a_mem[(base + x) & 1023] = v;
                1:       b_mem[(base + x) & 1023] = v;
                default: c_mem[(base + x) & 1023] = v;
            endcase
        end
    endtask

    // Pulses start for one cycle; t_start is the index of the edge that samples it.
    task automatic launch(input int opv, input int sh, input int ab, input int bb, input int cb);
        push_expected(opv, sh, ab, bb, cb);
        @(negedge clk);
        op     = 2'(opv);
        shift  = 5'(sh);
        a_base = 10'(ab);
        b_base = 10'(bb);
        c_base = 10'(cb);
        start  = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        t_start = cyc;
    endtask

    // Returns cycles from the start edge to done, or -1 if done never came.
    task automatic wait_done(input int limit, output int lat);
        lat = -1;
        for (int n = 0; n < limit; n++) begin
            if (done === 1'b1) begin
                lat = cyc - t_start;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, c_we} !== 3'b000) begin
            miscompares++;
            $display("FAIL reset_ctrl got busy/done/c_we=%b expected 000", {busy, done, c_we});
        end
        vectors++;
        if ({a_addr, b_addr, c_addr, c_din} !== 38'd0) begin
            miscompares++;
            $display("FAIL reset_data got a=%0d b=%0d c=%0d din=%0d expected all 0", a_addr, b_addr, c_addr, c_din);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, done} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_release got busy/done=%b expected 00", {busy, done});
        end
    endtask

    // Uniform A, B (and C preload) with a known constant result in every C entry.
    task automatic test_uniform(input string name, input int opv, input int av, input int bv, input int cv,
                                input int sh, input int exp_c, input int exp_lat);
        int lat;
        fill(0, 'h000, 64, av, 1'b0);
        fill(1, 'h100, 64, bv, 1'b0);
        fill(2, 'h200, 16, cv, 1'b0);
        launch(opv, sh, 'h000, 'h100, 'h200);
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s_busy got %b expected 1", name, busy);
        end
        wait_done(1000, lat);
        vectors++;
        if (lat !== exp_lat) begin
            miscompares++;
            $display("FAIL %s_latency got %0d expected %0d", name, lat, exp_lat);
        end
        @(negedge clk);
        vectors++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done_pulse got done=%b busy=%b expected 0 0", name, done, busy);
        end
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_write_count got %0d writes missing expected 0", name, exp_q.size());
            exp_q.delete();
        end
        for (int x = 0; x < 16; x++) begin
            vectors++;
            if (c_mem['h200 + x] !== 8'(exp_c)) begin
                miscompares++;
                $display("FAIL %s_c[%0d] got %0d expected %0d", name, x, $signed(c_mem['h200 + x]), exp_c);
            end
        end
    endtask

    task automatic test_random();
        int lat;
        int sh;
        int exp_lat;
        for (int n = 0; n < 4; n++) begin
            fill(0, 'h000, 64, 0, 1'b1);
            fill(1, 'h100, 64, 0, 1'b1);
            fill(2, 'h200, 16, 0, 1'b1);
            sh      = (n == 0) ? 7 : (n == 1) ? 9 : (n == 2) ? 0 : 1;
            exp_lat = (n == 0) ? 289 : (n == 1) ? 305 : 49;
            launch(n, sh, 'h000, 'h100, 'h200);
            wait_done(1000, lat);
            vectors++;
            if (lat !== exp_lat) begin
                miscompares++;
                $display("FAIL random_op%0d_latency got %0d expected %0d", n, lat, exp_lat);
            end
            @(negedge clk);
            vectors++;
            if (exp_q.size() != 0) begin
                miscompares++;
                $display("FAIL random_op%0d_write_count got %0d missing expected 0", n, exp_q.size());
                exp_q.delete();
            end
        end
    endtask

    task automatic test_ignore_start();
        int lat;
        int t1;
        fill(0, 'h000, 64, 1, 1'b0);
        fill(1, 'h100, 64, 1, 1'b0);
        fill(0, 'h040, 16, 2, 1'b0);
        fill(1, 'h140, 16, 3, 1'b0);
        fill(2, 'h300, 16, 0, 1'b0);
        launch(OP_MM, 0, 'h000, 'h100, 'h200);
        t1 = t_start;
        while (cyc < t1 + 10) @(negedge clk);
        op     = 2'(OP_ADD);
        a_base = 10'h040;
        b_base = 10'h140;
        c_base = 10'h300;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // FIN cycle: a request here must be dropped.
        while (cyc < t1 + 288) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        vectors++;
        if (done !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_fin_done got %b expected 1", done);
        end
        push_expected(OP_ADD, 0, 'h040, 'h140, 'h240);
        c_base = 10'h240;
        @(negedge clk);
        start   = 1'b0;
        t_start = cyc;
        vectors++;
        if (busy !== 1'b1) begin
            miscompares++;
            $display("FAIL ignore_restart_busy got %b expected 1", busy);
        end
        wait_done(200, lat);
        vectors++;
        if (lat !== 49) begin
            miscompares++;
            $display("FAIL ignore_restart_latency got %0d expected 49", lat);
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL ignore_write_count got %0d missing expected 0", exp_q.size());
            exp_q.delete();
        end
        vectors++;
        if (c_mem['h240] !== 8'd5 || c_mem['h300] !== 8'd0) begin
            miscompares++;
            $display("FAIL ignore_new_bases got c[240h]=%0d c[300h]=%0d expected 5 0", c_mem['h240], c_mem['h300]);
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit saw_done;
        fill(0, 'h000, 64, 0, 1'b1);
        fill(1, 'h100, 64, 0, 1'b1);
        launch(OP_MM, 3, 'h000, 'h100, 'h200);
        // Element 5 occupies MAC cycles t_start+90 .. t_start+105.
        while (cyc < t_start + 96) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, done, c_we, a_addr, b_addr, c_addr, c_din} !== 41'd0) begin
            miscompares++;
            $display("FAIL midreset_outputs got busy=%b done=%b we=%b a=%0d b=%0d c=%0d din=%0d expected all 0",
                     busy, done, c_we, a_addr, b_addr, c_addr, c_din);
        end
        vectors++;
        if (exp_q.size() != 11) begin
            miscompares++;
            $display("FAIL midreset_writes_before got %0d pending expected 11", exp_q.size());
        end
        exp_q.delete();
        @(negedge clk);
        rst_n    = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        vectors++;
        if (saw_done !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_idle got saw_done=%b busy=%b expected 0 0", saw_done, busy);
        end
        fill(0, 'h000, 16, 10, 1'b0);
        fill(1, 'h100, 16, 20, 1'b0);
        launch(OP_ADD, 0, 'h000, 'h100, 'h200);
        wait_done(200, lat);
        vectors++;
        if (lat !== 49) begin
            miscompares++;
            $display("FAIL midreset_fresh_latency got %0d expected 49", lat);
        end
        @(negedge clk);
        vectors++;
        if (exp_q.size() != 0 || c_mem['h20F] !== 8'd30) begin
            miscompares++;
            $display("FAIL midreset_fresh_result got pending=%0d c[20Fh]=%0d expected 0 30", exp_q.size(), c_mem['h20F]);
            exp_q.delete();
        end
    endtask

    initial begin
        for (int x = 0; x < 1024; x++) begin
            a_mem[x] = 8'd0;
            b_mem[x] = 8'd0;
            c_mem[x] = 8'd0;
        end
        test_reset();
        test_uniform("mm_ones",      OP_MM,     1,    2,   0, 0,   32, 289);
        test_uniform("mm_sat_hi",    OP_MM,     127,  127, 0, 0,  127, 289);
        test_uniform("mm_shift12",   OP_MM,     127,  127, 0, 12,  63, 289);
        test_uniform("mm_neg_floor", OP_MM,     -128, 127, 0, 12, -64, 289);
        test_uniform("mm_acc",       OP_MMACC,  1,    1,   5, 0,   21, 305);
        test_uniform("add_sat",      OP_ADD,    100,  100, 0, 0,  127, 49);
        test_uniform("sub_sat",      OP_SUB,    -100, 100, 0, 0, -128, 49);
        test_uniform("add_mixed",    OP_ADD,    3,    -7,  0, 0,   -4, 49);
        test_random();
        test_ignore_start();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tile_mac_engine.md
Name: tile_mac_engine

Overview:
Parametrised tile compute engine that streams operands from A/B SRAMs and writes results into C SRAM. Supports signed tiled matrix multiply, multiply-accumulate into existing C contents, and elementwise add/sub, with programmable right-shift and saturation. Sits beside the NPU controller as the next-generation tile processor: arbitrary tile sizes, base-address addressing, signed saturating output.

Parameters:
DATA_W, 8, element width (signed two's complement) of A, B and C.
ACC_W, 32, accumulator width (signed); must be >= 2*DATA_W + clog2(TK).
TM, 4, rows of A and C tile.
TN, 4, columns of B and C tile.
TK, 16, inner dimension (columns of A, rows of B).
ADDR_W, 10, SRAM address width.

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only in IDLE
op  in  2  0=MATMUL, 1=MATMUL_ACC, 2=ADD, 3=SUB; captured on accepted start
shift  in  clog2(ACC_W)  arithmetic right shift applied before saturation; captured on accepted start
a_base, b_base, c_base  in  ADDR_W each  tile base addresses; captured on accepted start
a_addr, b_addr  out  ADDR_W  read addresses; SRAM read data valid the cycle after the address
a_dout, b_dout  in  DATA_W  read data
c_addr  out  ADDR_W  C read/write address
c_we  out  1  C write strobe
c_din  out  DATA_W  C write data
c_dout  in  DATA_W  C read data (1-cycle latency), used by MATMUL_ACC
busy  out  1  high from cycle after accepted start until done cycle
done  out  1  one-cycle pulse after final write

Behaviour:
- Reset (async, rst_n=0): state IDLE; busy, done, c_we = 0; a_addr, b_addr, c_addr, c_din = 0; accumulator and counters cleared. Reset mid-operation aborts immediately; no further writes; partial C contents left as-is.
- States: IDLE, RDC, MAC, DRAIN, WRITE, FIN.
- IDLE: done=0. On start=1, capture op/shift/bases, set element indices i=j=0. Next state RDC if op=MATMUL_ACC, else MAC. start while not IDLE is ignored (no queuing).
- Element loop: elements in row-major order (i outer 0..TM-1, j inner 0..TN-1).
- RDC (1 cycle): c_addr = c_base + i*TN + j.
- MAC: k runs 0..K-1, where K=TK for MATMUL/MATMUL_ACC and K=1 for ADD/SUB. In each cycle, issue addresses:
  - Matmul: a_addr = a_base + i*TK + k; b_addr = b_base + k*TN + j.
  - Elementwise: a_addr = a_base + i*TN + j; b_addr = b_base + i*TN + j.
- Accumulator initialisation, in the first MAC cycle: acc = sign-extended c_dout for MATMUL_ACC (unshifted), else 0.
- Operand capture: data returned from the address issued in cycle k is consumed in cycle k+1:
  - MATMUL: acc += sext(a)*sext(b).
  - ADD: acc += sext(a) + sext(b).
  - SUB: acc += sext(a) - sext(b).
- DRAIN (1 cycle): consume the last returned operand pair.
- WRITE (1 cycle): c_we=1, c_addr = c_base + i*TN + j, c_din = sat(acc >>> shift).
  - sat clamps to [-2^(DATA_W-1), 2^(DATA_W-1)-1]; arithmetic shift floors toward minus infinity.
  - Then advance j, wrapping to 0 and incrementing i. Last element goes to FIN, else RDC/MAC.
- FIN: done=1 for exactly one cycle, busy=0, c_we=0; return to IDLE. start in FIN is ignored; accepted in the following IDLE cycle.
- c_we is high only in WRITE cycles. Each C address is written exactly once per operation.
- Cycles per element: K+2 (plus 1 for MATMUL_ACC).
- Latency from start edge to done-high edge:
  - MATMUL: TM*TN*(TK+2)+1.
  - MATMUL_ACC: TM*TN*(TK+3)+1.
  - ADD/SUB: TM*TN*3+1.
- Accumulation is exact in ACC_W; no internal overflow for legal parameters.

Test Plan:
- Defaults, MATMUL, A all 1, B all 2, shift 0 -> all 16 C entries = 32; done high exactly 289 cycles after start; 16 c_we pulses at c_base..c_base+15 in order.
- MATMUL with A all 127, B all 127 (acc 258064):
  - shift 0 -> C=127.
  - shift 12 -> C=63.
  - A all -128, shift 12 -> C=-64 (acc -260096, floor).
- MATMUL_ACC, C preloaded with 5, A=B=1, shift 0 -> C=21; latency 305 cycles; c_addr shows read then write per element.
- Elementwise saturation:
  - ADD, A=B=100 -> C=127.
  - SUB, A=-100, B=100 -> C=-128.
  - ADD, A=3, B=-7 -> C=-4; latency 49 cycles.
- start pulsed while busy, and again in the FIN cycle -> ignored, no extra writes; a start one cycle after done begins a new operation with newly captured bases.
- rst_n dropped mid-MAC of element 5 -> outputs 0 asynchronously; after release the engine idles with no writes or done; a fresh start then completes normally.
